// File: rtl/zet_front_fifo_wn2b.sv
// Wide-to-byte instruction prefetch FIFO: IN_W-bit words in, one byte out per pop, MSB byte first.
// Optional lookahead port (do8_nxt / next2_i) is enabled by defining ZET_FRONT_FIFO_PEEK_EN.
module zet_front_fifo_wn2b #(
  parameter int IN_W      = 16,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [$clog2(IN_W/8)-1:0]    skip_i,
  input  logic                         stb_i,
  input  logic [IN_W-1:0]              di,
  output logic                         full_o,
  output logic                         can_burst_o,
  output logic                         ovf_o,
  output logic                         do8_valid,
  output logic [7:0]                   do8,
`ifdef ZET_FRONT_FIFO_PEEK_EN
  output logic [7:0]                   do8_nxt,
  output logic                         do8_nxt_valid,
  input  logic                         next2_i,
`endif
  input  logic                         next_i
);

  localparam int BYTES = IN_W / 8;
  localparam int CAP   = DEPTH * BYTES;
  localparam int PW    = $clog2(DEPTH);
  localparam int SW    = $clog2(BYTES);
  localparam int LW    = $clog2(CAP) + 1;

  logic [IN_W-1:0] mem [DEPTH];

  // The byte-granular consume pointer is kept as {word, byte-in-word} so that
  // non-power-of-two word widths (e.g. 24 bits) still wrap correctly.
  logic [PW-1:0] produce;
  logic [PW-1:0] c_word;
  logic [SW-1:0] c_byte;
  logic [SW-1:0] skip_pend;
  logic [LW-1:0] level;
  logic          ovf_q;

  logic [LW-1:0]    free_b;
  logic [LW-1:0]    level_nxt;
  logic [PW+SW-1:0] pos1;
  logic             wr_acc;
  logic             pop1;
  logic [1:0]       pop_cnt;

  function automatic logic [7:0] pick(input logic [IN_W-1:0] w, input logic [SW-1:0] b);
    pick = w[IN_W-8-8*int'(b) +: 8];
  endfunction

  function automatic logic [PW+SW-1:0] bump(input logic [PW-1:0] w, input logic [SW-1:0] b);
    if (b == SW'(BYTES-1)) bump = {w + PW'(1), SW'(0)};
    else                   bump = {w, b + SW'(1)};
  endfunction

  assign free_b      = LW'(CAP) - level;
  assign full_o      = free_b < LW'(BYTES);
  assign can_burst_o = free_b >= LW'(BURST_LEN * BYTES);
  assign do8_valid   = level != '0;
  assign ovf_o       = ovf_q;
  assign do8         = pick(mem[c_word], c_byte);
  assign pos1        = bump(c_word, c_byte);

  // Space is judged on the pre-edge level, so a same-cycle pop never makes room for a write.
  assign wr_acc = stb_i && !full_o && !flush_i;

`ifdef ZET_FRONT_FIFO_PEEK_EN
  logic [PW+SW-1:0] pos2;
  logic             pop2;

  assign pos2          = bump(pos1[PW+SW-1:SW], pos1[SW-1:0]);
  assign do8_nxt       = pick(mem[pos1[PW+SW-1:SW]], pos1[SW-1:0]);
  assign do8_nxt_valid = level >= LW'(2);
  assign pop2          = next2_i && do8_nxt_valid && !flush_i;
  assign pop1          = next_i && !next2_i && do8_valid && !flush_i;
`else
  assign pop1          = next_i && do8_valid && !flush_i;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pop_cnt = 2'd0;
    if (pop1) pop_cnt = 2'd1;
`ifdef ZET_FRONT_FIFO_PEEK_EN
    if (pop2) pop_cnt = 2'd2;
`endif
    level_nxt = level - LW'(pop_cnt);
    if (wr_acc) level_nxt = level_nxt + LW'(BYTES) - LW'(skip_pend);
  end

  // NOTE: word storage has no reset; only pointers and level define what is valid,
  // which lets the array map onto LUT RAM.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[produce] <= di;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      produce   <= '0;
      c_word    <= '0;
      c_byte    <= '0;
      skip_pend <= '0;
      level     <= '0;
      ovf_q     <= 1'b0;
    end else if (flush_i) begin
      produce   <= '0;
      c_word    <= '0;
      c_byte    <= skip_i;
      skip_pend <= skip_i;
      level     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      level <= level_nxt;
      if (wr_acc) begin
        produce   <= produce + PW'(1);
        skip_pend <= '0;
      end
      if (stb_i && full_o) ovf_q <= 1'b1;
      if (pop1) {c_word, c_byte} <= pos1;
`ifdef ZET_FRONT_FIFO_PEEK_EN
      if (pop2) {c_word, c_byte} <= pos2;
`endif
    end
  end

endmodule

// File: tb/tb_zet_front_fifo_wn2b.sv
// Directed bench for zet_front_fifo_wn2b at IN_W=16, DEPTH=8, BURST_LEN=4.
// Lookahead scenario is compiled in only when ZET_FRONT_FIFO_PEEK_EN is defined.
module tb_zet_front_fifo_wn2b;

  localparam int CAP = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic [0:0]  skip_i = 1'b0;
  logic        stb_i = 1'b0;
  logic [15:0] di = 16'h0;
  logic        next_i = 1'b0;
  logic        full_o, can_burst_o, ovf_o, do8_valid;
  logic [7:0]  do8;
`ifdef ZET_FRONT_FIFO_PEEK_EN
  logic [7:0]  do8_nxt;
  logic        do8_nxt_valid;
  logic        next2_i = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  zet_front_fifo_wn2b #(.IN_W(16), .DEPTH(8), .BURST_LEN(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .skip_i(skip_i),
    .stb_i(stb_i), .di(di), .full_o(full_o), .can_burst_o(can_burst_o),
    .ovf_o(ovf_o), .do8_valid(do8_valid), .do8(do8),
`ifdef ZET_FRONT_FIFO_PEEK_EN
    .do8_nxt(do8_nxt), .do8_nxt_valid(do8_nxt_valid), .next2_i(next2_i),
`endif
    .next_i(next_i)
  );

  always #5 clk_i = ~clk_i;

  // One clock with the given inputs held; returns 1 time unit after the edge.
  task automatic cyc(input logic stb, input logic [15:0] d, input logic nx,
                     input logic fl, input logic [0:0] sk);
    stb_i = stb; di = d; next_i = nx; flush_i = fl; skip_i = sk;
    @(posedge clk_i); #1;
    stb_i = 1'b0; next_i = 1'b0; flush_i = 1'b0; skip_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({do8_valid, full_o, can_burst_o, ovf_o} !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_flags got valid/full/burst/ovf=%b want=0010",
               {do8_valid, full_o, can_burst_o, ovf_o});
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    vectors++;
    if ({do8_valid, full_o, can_burst_o, ovf_o} !== 4'b0010) begin
      miscompares++;
      $display("FAIL post_reset_flags got %b want=0010", {do8_valid, full_o, can_burst_o, ovf_o});
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [4];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    cyc(1, 16'hA1B2, 0, 0, 0);
    cyc(1, 16'hC3D4, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (do8_valid !== 1'b1 || do8 !== exp_b[i]) begin
        miscompares++;
        $display("FAIL basic_byte%0d got valid=%b do8=%h want valid=1 do8=%h", i, do8_valid, do8, exp_b[i]);
      end
      cyc(0, 16'h0, 1, 0, 0);
    end
    vectors++;
    if (do8_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_empty got valid=%b want=0", do8_valid);
    end
  endtask

  task automatic test_full_ovf();
    for (int i = 0; i < 8; i++) begin
      cyc(1, {8'(8'h20 + 2*i), 8'(8'h21 + 2*i)}, 0, 0, 0);
      if (i == 3) begin
        vectors++;
        if (can_burst_o !== 1'b1 || full_o !== 1'b0) begin
          miscompares++;
          $display("FAIL burst_at_level8 got burst=%b full=%b want burst=1 full=0", can_burst_o, full_o);
        end
      end
      if (i == 4) begin
        vectors++;
        if (can_burst_o !== 1'b0) begin
          miscompares++;
          $display("FAIL burst_at_level10 got burst=%b want=0", can_burst_o);
        end
      end
      if (i == 6) begin
        vectors++;
        if (full_o !== 1'b0) begin
          miscompares++;
          $display("FAIL full_at_level14 got full=%b want=0", full_o);
        end
      end
    end
    vectors++;
    if ({full_o, can_burst_o, ovf_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL full_at_level16 got full/burst/ovf=%b want=100", {full_o, can_burst_o, ovf_o});
    end
    cyc(1, 16'hDEAD, 0, 0, 0);
    vectors++;
    if ({full_o, ovf_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL overflow_drop got full/ovf=%b want=11", {full_o, ovf_o});
    end
    // Drain all 16 bytes; the dropped DEAD word must never appear.
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (do8_valid !== 1'b1 || do8 !== 8'(8'h20 + k)) begin
        miscompares++;
        $display("FAIL drain_byte%0d got valid=%b do8=%h want valid=1 do8=%h", k, do8_valid, do8, 8'(8'h20 + k));
      end
      cyc(0, 16'h0, 1, 0, 0);
      if (k == 0) begin
        vectors++;
        if (full_o !== 1'b1) begin
          miscompares++;
          $display("FAIL full_free1 got full=%b want=1", full_o);
        end
      end
      if (k == 1) begin
        vectors++;
        if (full_o !== 1'b0) begin
          miscompares++;
          $display("FAIL full_free2 got full=%b want=0", full_o);
        end
      end
    end
    vectors++;
    if ({do8_valid, ovf_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL drain_end got valid/ovf=%b want=01", {do8_valid, ovf_o});
    end
  endtask

  task automatic test_flush_skip();
    cyc(0, 16'h0, 0, 1, 1);
    vectors++;
    if ({do8_valid, full_o, can_burst_o, ovf_o} !== 4'b0010) begin
      miscompares++;
      $display("FAIL flush_flags got %b want=0010", {do8_valid, full_o, can_burst_o, ovf_o});
    end
    cyc(1, 16'h55AA, 0, 0, 0);
    vectors++;
    if (do8_valid !== 1'b1 || do8 !== 8'hAA) begin
      miscompares++;
      $display("FAIL skip_first got valid=%b do8=%h want valid=1 do8=aa", do8_valid, do8);
    end
    cyc(0, 16'h0, 1, 0, 0);
    vectors++;
    if ({do8_valid, ovf_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL skip_level1 got valid/ovf=%b want=00", {do8_valid, ovf_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    exp_b = '{8'h33, 8'h44, 8'h55, 8'h66};
    cyc(0, 16'h0, 0, 1, 1);
    cyc(1, 16'h1122, 0, 0, 0);
    cyc(1, 16'h3344, 0, 0, 0);
    vectors++;
    if (do8 !== 8'h22) begin
      miscompares++;
      $display("FAIL simul_pre got do8=%h want=22", do8);
    end
    cyc(1, 16'h5566, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (do8_valid !== 1'b1 || do8 !== exp_b[i]) begin
        miscompares++;
        $display("FAIL simul_byte%0d got valid=%b do8=%h want valid=1 do8=%h", i, do8_valid, do8, exp_b[i]);
      end
      cyc(0, 16'h0, 1, 0, 0);
    end
    vectors++;
    if (do8_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_level4 got valid=%b want=0", do8_valid);
    end
    cyc(1, 16'h7788, 0, 0, 0);
    cyc(1, 16'h9900, 1, 1, 0);
    cyc(0, 16'h0, 0, 0, 0);
    vectors++;
    if ({do8_valid, full_o, can_burst_o} !== 3'b001) begin
      miscompares++;
      $display("FAIL flush_priority got valid/full/burst=%b want=001", {do8_valid, full_o, can_burst_o});
    end
  endtask

  task automatic test_stream();
    logic [7:0]  q [$];
    logic        do_wr, do_pop;
    logic [15:0] w;
    int sent = 0;
    int cycles = 0;
    while ((sent < 40 || q.size() != 0) && cycles < 2000) begin
      vectors++;
      if (do8_valid !== (q.size() != 0) || (q.size() != 0 && do8 !== q[0])) begin
        miscompares++;
        $display("FAIL stream_cycle%0d got valid=%b do8=%h want valid=%b do8=%h",
                 cycles, do8_valid, do8, q.size() != 0, (q.size() != 0) ? q[0] : 8'h00);
      end
      do_wr  = (sent < 40) && (q.size() <= CAP - 2) && ($urandom_range(0, 3) != 0);
      do_pop = (sent >= 40) || ($urandom_range(0, 2) != 0);
      w = 16'(sent * 16'h0103 + 16'h0A05);
      cyc(do_wr, w, do_pop, 0, 0);
      if (do_pop && q.size() != 0) void'(q.pop_front());
      if (do_wr) begin
        q.push_back(w[15:8]);
        q.push_back(w[7:0]);
        sent++;
      end
      cycles++;
    end
    vectors++;
    if (cycles >= 2000) begin
      miscompares++;
      $display("FAIL stream_timeout got cycles=%0d want<2000", cycles);
    end
    // Asynchronous reset mid-stream must clear state before the next edge.
    cyc(1, 16'h1234, 0, 0, 0);
    cyc(1, 16'h5678, 0, 0, 0);
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({do8_valid, full_o, can_burst_o, ovf_o} !== 4'b0010) begin
      miscompares++;
      $display("FAIL async_reset got %b want=0010", {do8_valid, full_o, can_burst_o, ovf_o});
    end
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    cyc(1, 16'hBEEF, 0, 0, 0);
    vectors++;
    if (do8_valid !== 1'b1 || do8 !== 8'hBE) begin
      miscompares++;
      $display("FAIL post_reset_write got valid=%b do8=%h want valid=1 do8=be", do8_valid, do8);
    end
    cyc(0, 16'h0, 1, 0, 0);
    cyc(0, 16'h0, 1, 0, 0);
    vectors++;
    if (do8_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_level got valid=%b want=0", do8_valid);
    end
  endtask

`ifdef ZET_FRONT_FIFO_PEEK_EN
  task automatic test_peek();
    cyc(0, 16'h0, 0, 1, 1);
    cyc(1, 16'hEE11, 0, 0, 0);
    cyc(1, 16'h2233, 0, 0, 0);
    vectors++;
    if (do8 !== 8'h11 || do8_nxt !== 8'h22 || do8_nxt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL peek_initial got do8=%h nxt=%h nv=%b want 11 22 1", do8, do8_nxt, do8_nxt_valid);
    end
    next2_i = 1'b1;
    @(posedge clk_i); #1;
    next2_i = 1'b0;
    vectors++;
    if (do8_valid !== 1'b1 || do8 !== 8'h33 || do8_nxt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL peek_pop2 got valid=%b do8=%h nv=%b want 1 33 0", do8_valid, do8, do8_nxt_valid);
    end
    next2_i = 1'b1;
    @(posedge clk_i); #1;
    next2_i = 1'b0;
    vectors++;
    if (do8_valid !== 1'b1 || do8 !== 8'h33) begin
      miscompares++;
      $display("FAIL peek_pop2_short got valid=%b do8=%h want 1 33", do8_valid, do8);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full_ovf();
    test_flush_skip();
    test_back_to_back();
    test_stream();
`ifdef ZET_FRONT_FIFO_PEEK_EN
    test_peek();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
